// File: rtl/z80_bus_pkg.sv
// Shared types for the tv80s bus responder.
//   bus_state_t : bus FSM states
//   log_entry_t : one write-log record {is_io, addr, data}
//   LOG_W       : packed width of log_entry_t
package z80_bus_pkg;

    localparam int LOG_W = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } bus_state_t;

    typedef struct packed {
        logic        is_io;
        logic [15:0] addr;
        logic [7:0]  data;
    } log_entry_t;

endpackage

// File: rtl/z80_log_fifo.sv
// Write-log FIFO for the bus responder.
//   clk, rst_n            : falling-edge clock, async active-low reset
//   push, push_data       : append an entry (dropped when full unless a pop
//                           happens on the same edge)
//   pop_valid, pop_data   : head entry, valid while non-empty
//   pop_ready             : consume head when pop_valid is high
//   count                 : entries held
//   overflow              : sticky, set when a push was dropped
module z80_log_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       pop_valid,
    output logic [WIDTH-1:0]           pop_data,
    input  logic                       pop_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             full, push_ok, pop_ok;

    assign pop_valid = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop_ok    = pop_ready & pop_valid;
    // A pop on the same edge frees the slot, so a push into a full FIFO is
    // still accepted then (wptr == rptr, head is read before the overwrite).
    assign push_ok   = push & (~full | pop_ok);
    assign pop_data  = store[rptr];

    always_ff @(negedge clk) begin
        if (push_ok) store[wptr] <= push_data;
    end

    // The whole responder runs on the falling edge of the CPU clock.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push & ~push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/z80_bus_responder.sv
// Memory / I/O responder for the tv80s CPU bus.
// Serves reads and writes with per-type wait states, logs every committed
// CPU write into a drainable FIFO, and offers a backdoor preload port.
//   i_clk, i_reset_n              : clock (state on falling edge), async reset
//   i_a, strobes, i_do            : CPU bus in
//   o_di, o_wait_n                : read data / wait request to the CPU
//   i_bd_*                        : backdoor write (not logged)
//   o_log_*, i_log_ready          : write-log FIFO head, pop, count, overflow
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int MEM_AW    = 16,
    parameter int IO_AW     = 8,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 0,
    parameter int LOG_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [15:0]                   i_a,
    input  logic                          i_mreq_n,
    input  logic                          i_iorq_n,
    input  logic                          i_rd_n,
    input  logic                          i_wr_n,
    input  logic                          i_m1_n,
    input  logic                          i_rfsh_n,
    input  logic [7:0]                    i_do,
    output logic [7:0]                    o_di,
    output logic                          o_wait_n,
    input  logic                          i_bd_we,
    input  logic                          i_bd_io,
    input  logic [15:0]                   i_bd_addr,
    input  logic [7:0]                    i_bd_data,
    output logic                          o_log_valid,
    output logic [LOG_W-1:0]              o_log_entry,
    input  logic                          i_log_ready,
    output logic [$clog2(LOG_DEPTH):0]    o_log_count,
    output logic                          o_log_overflow
);
    logic [7:0] mem [2**MEM_AW];
    logic [7:0] io  [2**IO_AW];

    bus_state_t state;
    logic [3:0] wcnt;
    logic       cyc_io;

    logic rfsh_cyc, inta_cyc, mem_cyc, io_cyc, bus_end;
    logic acc_io, access, rd_now, wr_now;
    logic [3:0] wload;
    logic [MEM_AW-1:0] mem_addr;
    logic [IO_AW-1:0]  io_addr;
    logic [7:0]        rd_data;
    log_entry_t        push_entry;

    // Cycle classification, highest priority first.
    assign rfsh_cyc = ~i_mreq_n & ~i_rfsh_n;
    assign inta_cyc = ~rfsh_cyc & ~i_iorq_n & ~i_m1_n;
    assign mem_cyc  = ~rfsh_cyc & ~inta_cyc & ~i_mreq_n;
    assign io_cyc   = ~rfsh_cyc & ~inta_cyc & i_mreq_n & ~i_iorq_n;
    // A refresh following an access also terminates it.
    assign bus_end  = (i_mreq_n & i_iorq_n) | rfsh_cyc;

    assign wload  = io_cyc ? 4'(IO_WAIT) : 4'(MEM_WAIT);
    assign acc_io = (state == IDLE) ? io_cyc : cyc_io;

    // The access happens on the edge that releases o_wait_n (or the first
    // edge of a zero-wait cycle) so data is ready for the next rising edge.
    always_comb begin
        access = 1'b0;
        case (state)
            IDLE:    access = (mem_cyc | io_cyc) & (wload == 4'd0);
            WAIT:    access = ~bus_end & (wcnt == 4'd1);
            ACCESS:  access = ~bus_end;
            default: access = 1'b0;
        endcase
    end

    assign rd_now   = access & ~i_rd_n;
    assign wr_now   = access & ~i_wr_n;
    assign mem_addr = i_a[MEM_AW-1:0];
    assign io_addr  = i_a[IO_AW-1:0];
    assign rd_data  = acc_io ? io[io_addr] : mem[mem_addr];

    // Arrays are not reset. The CPU write is last so it wins a collision
    // with the backdoor on the same address.
    always_ff @(negedge i_clk) begin
        if (i_bd_we & ~i_bd_io) mem[i_bd_addr[MEM_AW-1:0]] <= i_bd_data;
        if (i_bd_we &  i_bd_io) io[i_bd_addr[IO_AW-1:0]]   <= i_bd_data;
        if (wr_now & ~acc_io)   mem[mem_addr]              <= i_do;
        if (wr_now &  acc_io)   io[io_addr]                <= i_do;
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            wcnt     <= 4'd0;
            cyc_io   <= 1'b0;
            o_wait_n <= 1'b1;
            o_di     <= 8'hFF;
        end else begin
            if (rd_now) o_di <= rd_data;
            case (state)
                IDLE: begin
                    if (inta_cyc) begin
                        o_di <= 8'hFF;
                    end else if (mem_cyc | io_cyc) begin
                        cyc_io <= io_cyc;
                        wcnt   <= wload;
                        if (wload != 4'd0) begin
                            state    <= WAIT;
                            o_wait_n <= 1'b0;
                        end else begin
                            state <= wr_now ? HOLD : ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (bus_end) begin
                        state    <= IDLE;
                        wcnt     <= 4'd0;
                        o_wait_n <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                        if (wcnt == 4'd1) begin
                            o_wait_n <= 1'b1;
                            state    <= wr_now ? HOLD : ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (bus_end)     state <= IDLE;
                    else if (wr_now) state <= HOLD;
                end
                HOLD: begin
                    if (bus_end) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push_entry = '{is_io: acc_io, addr: i_a, data: i_do};

    z80_log_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .push      (wr_now),
        .push_data (push_entry),
        .pop_valid (o_log_valid),
        .pop_data  (o_log_entry),
        .pop_ready (i_log_ready),
        .count     (o_log_count),
        .overflow  (o_log_overflow)
    );

endmodule

// File: tb/tb_z80_bus_responder.sv
module tb_z80_bus_responder;
    localparam int MW = 2;
    localparam int IW = 1;
    localparam int LD = 4;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [15:0] i_a = '0;
    logic        i_mreq_n = 1'b1, i_iorq_n = 1'b1, i_rd_n = 1'b1, i_wr_n = 1'b1;
    logic        i_m1_n = 1'b1, i_rfsh_n = 1'b1;
    logic [7:0]  i_do = '0;
    logic        i_bd_we = 1'b0, i_bd_io = 1'b0;
    logic [15:0] i_bd_addr = '0;
    logic [7:0]  i_bd_data = '0;
    logic        i_log_ready = 1'b0;

    logic [7:0]  o_di, o_di0;
    logic        o_wait_n, o_wait_n0;
    logic        o_log_valid, o_log_valid0, o_log_overflow, o_log_overflow0;
    logic [24:0] o_log_entry, o_log_entry0;
    logic [2:0]  o_log_count;
    logic [4:0]  o_log_count0;

    always #5 i_clk = ~i_clk;

    z80_bus_responder #(.MEM_WAIT(MW), .IO_WAIT(IW), .LOG_DEPTH(LD)) u_dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_a(i_a),
        .i_mreq_n(i_mreq_n), .i_iorq_n(i_iorq_n), .i_rd_n(i_rd_n), .i_wr_n(i_wr_n),
        .i_m1_n(i_m1_n), .i_rfsh_n(i_rfsh_n), .i_do(i_do), .o_di(o_di), .o_wait_n(o_wait_n),
        .i_bd_we(i_bd_we), .i_bd_io(i_bd_io), .i_bd_addr(i_bd_addr), .i_bd_data(i_bd_data),
        .o_log_valid(o_log_valid), .o_log_entry(o_log_entry), .i_log_ready(i_log_ready),
        .o_log_count(o_log_count), .o_log_overflow(o_log_overflow));

    // Zero-wait, default-depth instance sharing the same bus.
    z80_bus_responder u_dut0 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_a(i_a),
        .i_mreq_n(i_mreq_n), .i_iorq_n(i_iorq_n), .i_rd_n(i_rd_n), .i_wr_n(i_wr_n),
        .i_m1_n(i_m1_n), .i_rfsh_n(i_rfsh_n), .i_do(i_do), .o_di(o_di0), .o_wait_n(o_wait_n0),
        .i_bd_we(i_bd_we), .i_bd_io(i_bd_io), .i_bd_addr(i_bd_addr), .i_bd_data(i_bd_data),
        .o_log_valid(o_log_valid0), .o_log_entry(o_log_entry0), .i_log_ready(i_log_ready),
        .o_log_count(o_log_count0), .o_log_overflow(o_log_overflow0));

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: byte arrays, a bounded write-log queue, sticky overflow.
    logic [7:0]  mem_m [int];
    logic [7:0]  io_m  [int];
    logic [24:0] q [$];
    bit          ovf_m = 1'b0;
    bit          dut0_sync = 1'b1;

    typedef struct {
        bit          is_io;
        bit          is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_rd;
        int          exp_waits;
        int          exp_cnt;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic strobes_off();
        i_mreq_n = 1'b1; i_iorq_n = 1'b1; i_rd_n = 1'b1; i_wr_n = 1'b1;
        i_m1_n = 1'b1; i_rfsh_n = 1'b1;
    endtask

    task automatic bd_write(input bit io, input logic [15:0] a, input logic [7:0] d);
        @(posedge i_clk);
        i_bd_we = 1'b1; i_bd_io = io; i_bd_addr = a; i_bd_data = d;
        @(posedge i_clk);
        i_bd_we = 1'b0;
        if (io) io_m[int'(a[7:0])] = d; else mem_m[int'(a)] = d;
    endtask

    task automatic model_write(input bit io, input logic [15:0] a, input logic [7:0] d);
        if (io) io_m[int'(a[7:0])] = d; else mem_m[int'(a)] = d;
        if (q.size() < LD) q.push_back({io, a, d});
        else ovf_m = 1'b1;
    endtask

    // One CPU cycle with strobes held until o_wait_n is sampled high.
    task automatic bus_cycle(input bit is_io, input bit is_wr, input logic [15:0] addr,
                             input logic [7:0] data, output logic [7:0] rd,
                             output int waits, output logic [7:0] rd0, output bit w0);
        int n;
        @(posedge i_clk);
        i_a = addr; i_do = data;
        i_mreq_n = is_io; i_iorq_n = !is_io;
        i_rd_n = is_wr; i_wr_n = !is_wr;
        waits = 0; w0 = 1'b0; n = 0;
        do begin
            @(posedge i_clk);
            if (!o_wait_n0) w0 = 1'b1;
            if (!o_wait_n) waits++;
            n++;
        end while (!o_wait_n && n < 20);
        chk("bus_done", 32'(o_wait_n), 32'd1);
        rd = o_di; rd0 = o_di0;
        strobes_off();
    endtask

    task automatic pop_one(input string nm);
        @(posedge i_clk);
        chk({nm, "_valid"}, 32'(o_log_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({nm, "_entry"}, 32'(o_log_entry), 32'(q[0]));
            if (dut0_sync) chk({nm, "_entry0"}, 32'(o_log_entry0), 32'(q[0]));
        end
        i_log_ready = 1'b1;
        @(posedge i_clk);
        i_log_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, rd0, exp;
        int waits;
        bit w0;

        tbl[0] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'hFD, 2, 0};
        tbl[1] = '{1'b0, 1'b0, 16'h0003, 8'h00, 8'h71, 2, 0};
        tbl[2] = '{1'b0, 1'b0, 16'h99C1, 8'h00, 8'h3E, 2, 0};
        tbl[3] = '{1'b0, 1'b1, 16'h8000, 8'h55, 8'h00, 2, 1};
        tbl[4] = '{1'b0, 1'b0, 16'h8000, 8'h00, 8'h55, 2, 1};
        tbl[5] = '{1'b1, 1'b1, 16'h007F, 8'hA5, 8'h00, 1, 2};
        tbl[6] = '{1'b1, 1'b0, 16'h007F, 8'h00, 8'hA5, 1, 2};
        tbl[7] = '{1'b1, 1'b0, 16'h017F, 8'h00, 8'hA5, 1, 2};
        tbl[8] = '{1'b0, 1'b0, 16'h0001, 8'h00, 8'hCB, 2, 2};

        // Reset state
        repeat (3) @(posedge i_clk);
        chk("rst_di", 32'(o_di), 32'hFF);
        chk("rst_wait", 32'(o_wait_n), 32'd1);
        chk("rst_valid", 32'(o_log_valid), 32'd0);
        chk("rst_count", 32'(o_log_count), 32'd0);
        chk("rst_ovf", 32'(o_log_overflow), 32'd0);
        chk("rst_count0", 32'(o_log_count0), 32'd0);
        chk("rst_ovf0", 32'(o_log_overflow0), 32'd0);
        @(posedge i_clk);
        i_reset_n = 1'b1;

        // Backdoor preload
        bd_write(1'b0, 16'h0000, 8'hFD);
        bd_write(1'b0, 16'h0001, 8'hCB);
        bd_write(1'b0, 16'h0002, 8'h27);
        bd_write(1'b0, 16'h0003, 8'h71);
        bd_write(1'b0, 16'h99C1, 8'h3E);
        for (int i = 0; i < 8; i++) begin
            bd_write(1'b0, 16'h4000 + 16'(i), 8'($urandom));
            bd_write(1'b1, 16'h0010 + 16'(i), 8'($urandom));
        end
        @(posedge i_clk);
        chk("bd_not_logged", 32'(o_log_count), 32'd0);

        // Table-driven accesses
        for (int i = 0; i < 9; i++) begin
            bus_cycle(tbl[i].is_io, tbl[i].is_wr, tbl[i].addr, tbl[i].data, rd, waits, rd0, w0);
            if (tbl[i].is_wr) model_write(tbl[i].is_io, tbl[i].addr, tbl[i].data);
            chk($sformatf("tbl%0d_waits", i), 32'(waits), 32'(tbl[i].exp_waits));
            chk($sformatf("tbl%0d_nowait0", i), 32'(w0), 32'd0);
            if (!tbl[i].is_wr) begin
                chk($sformatf("tbl%0d_rd", i), 32'(rd), 32'(tbl[i].exp_rd));
                chk($sformatf("tbl%0d_rd0", i), 32'(rd0), 32'(tbl[i].exp_rd));
            end
            chk($sformatf("tbl%0d_count", i), 32'(o_log_count), 32'(tbl[i].exp_cnt));
        end

        // Interrupt acknowledge: FF, no wait, no log
        @(posedge i_clk);
        i_iorq_n = 1'b0; i_m1_n = 1'b0;
        @(posedge i_clk);
        chk("inta_di", 32'(o_di), 32'hFF);
        chk("inta_wait", 32'(o_wait_n), 32'd1);
        strobes_off();
        // Refresh: no wait, no log
        @(posedge i_clk);
        i_a = 16'h0005; i_mreq_n = 1'b0; i_rfsh_n = 1'b0;
        repeat (2) @(posedge i_clk);
        chk("rfsh_wait", 32'(o_wait_n), 32'd1);
        strobes_off();
        @(posedge i_clk);
        chk("rfsh_count", 32'(o_log_count), 32'd2);

        // Drain the two logged writes
        while (q.size() != 0) pop_one("drain1");
        pop_one("drain1_empty");

        // i_wr_n held low across several falling edges: one entry only
        @(posedge i_clk);
        i_a = 16'h8001; i_do = 8'h3C; i_mreq_n = 1'b0; i_wr_n = 1'b0;
        repeat (6) @(posedge i_clk);
        strobes_off();
        model_write(1'b0, 16'h8001, 8'h3C);
        @(posedge i_clk);
        chk("hold_count", 32'(o_log_count), 32'(q.size()));

        // Backdoor and CPU hit the same address on the commit edge
        @(posedge i_clk);
        i_a = 16'h9000; i_do = 8'h77; i_mreq_n = 1'b0; i_wr_n = 1'b0;
        repeat (2) @(posedge i_clk);
        i_bd_we = 1'b1; i_bd_io = 1'b0; i_bd_addr = 16'h9000; i_bd_data = 8'h88;
        @(posedge i_clk);
        i_bd_we = 1'b0;
        strobes_off();
        model_write(1'b0, 16'h9000, 8'h77);
        bus_cycle(1'b0, 1'b0, 16'h9000, 8'h00, rd, waits, rd0, w0);
        chk("collide_rd", 32'(rd), 32'h77);

        // Fill the log, then push and pop on the same edge while full
        for (int i = 0; i < 2; i++) begin
            bus_cycle(1'b0, 1'b1, 16'h8010 + 16'(i), 8'h10 + 8'(i), rd, waits, rd0, w0);
            model_write(1'b0, 16'h8010 + 16'(i), 8'h10 + 8'(i));
        end
        chk("full_count", 32'(o_log_count), 32'd4);
        @(posedge i_clk);
        i_a = 16'h8014; i_do = 8'h14; i_mreq_n = 1'b0; i_wr_n = 1'b0;
        repeat (2) @(posedge i_clk);
        i_log_ready = 1'b1;
        @(posedge i_clk);
        i_log_ready = 1'b0;
        strobes_off();
        void'(q.pop_front());
        model_write(1'b0, 16'h8014, 8'h14);
        chk("pushpop_count", 32'(o_log_count), 32'd4);
        chk("pushpop_ovf", 32'(o_log_overflow), 32'd0);
        chk("pushpop_head", 32'(o_log_entry), 32'(q[0]));

        // Overflow: entry dropped, array still written
        bus_cycle(1'b0, 1'b1, 16'h8020, 8'h99, rd, waits, rd0, w0);
        model_write(1'b0, 16'h8020, 8'h99);
        dut0_sync = 1'b0;
        chk("ovf_count", 32'(o_log_count), 32'd4);
        chk("ovf_flag", 32'(o_log_overflow), 32'(ovf_m));
        bus_cycle(1'b0, 1'b0, 16'h8020, 8'h00, rd, waits, rd0, w0);
        chk("ovf_mem", 32'(rd), 32'h99);
        while (q.size() != 0) pop_one("drain2");
        chk("ovf_sticky", 32'(o_log_overflow), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            bit is_io, is_wr;
            logic [15:0] a;
            logic [7:0] d;
            int idx;
            is_io = 1'($urandom);
            is_wr = 1'($urandom);
            idx = int'($urandom_range(0, 7));
            a = is_io ? {8'($urandom), 8'h10 + 8'(idx)} : 16'h4000 + 16'(idx);
            d = 8'($urandom);
            exp = is_io ? io_m[int'(a[7:0])] : mem_m[int'(a)];
            bus_cycle(is_io, is_wr, a, d, rd, waits, rd0, w0);
            if (is_wr) begin
                model_write(is_io, a, d);
            end else begin
                chk("rnd_rd", 32'(rd), 32'(exp));
                chk("rnd_rd0", 32'(rd0), 32'(exp));
            end
            chk("rnd_waits", 32'(waits), 32'(is_io ? IW : MW));
            chk("rnd_nowait0", 32'(w0), 32'd0);
            chk("rnd_count", 32'(o_log_count), 32'(q.size()));
            chk("rnd_ovf", 32'(o_log_overflow), 32'(ovf_m));
            if ($urandom_range(0, 2) == 0) pop_one("rnd_pop");
        end

        // Reset asserted during a wait state
        @(posedge i_clk);
        i_a = 16'h0000; i_mreq_n = 1'b0; i_rd_n = 1'b0;
        @(posedge i_clk);
        chk("rstw_wait_low", 32'(o_wait_n), 32'd0);
        #2 i_reset_n = 1'b0;
        #1;
        chk("rstw_wait", 32'(o_wait_n), 32'd1);
        chk("rstw_di", 32'(o_di), 32'hFF);
        chk("rstw_valid", 32'(o_log_valid), 32'd0);
        chk("rstw_count", 32'(o_log_count), 32'd0);
        chk("rstw_ovf", 32'(o_log_overflow), 32'd0);
        strobes_off();
        @(posedge i_clk);
        i_reset_n = 1'b1;
        q.delete();
        ovf_m = 1'b0;
        bus_cycle(1'b0, 1'b0, 16'h0000, 8'h00, rd, waits, rd0, w0);
        chk("rstw_after_rd", 32'(rd), 32'hFD);
        chk("rstw_after_waits", 32'(waits), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
